weight_buffer_pingpong_gen: RTL and testbench

Parametrised ping-pong weight buffer feeding the systolic array's weight-load port.
- Input side: an AXI-Stream of IN_W-bit beats is packed by a gearbox into OUT_W-bit rows and written into the write bank.
- Output side: the read bank streams one row per cycle to the array while load is enabled.
- Differences from a fixed-ratio buffer: generic width ratio, generic depth, a per-tile row count, real backpressure, guarded bank swap, status flags and an output-valid strobe.

---
 rtl/wbuf_pkg.sv | 27 ++
 rtl/weight_buffer_pingpong_gen_if.sv | 14 +
 rtl/wbuf_gearbox.sv | 53 +++++
 rtl/weight_buffer_pingpong_gen.sv | 156 +++++++++++++++
 tb/tb_weight_buffer_pingpong_gen.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wbuf_pkg.sv
// Shared constants and helpers for the ping-pong weight buffer.
// Holds the default geometry, the derived ratio/address widths and a zero row.
package wbuf_pkg;

  // Ceiling log2 usable in constant expressions.
  function automatic int unsigned wbuf_clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  localparam int unsigned WBUF_IN_W  = 64;
  localparam int unsigned WBUF_OUT_W = 128;
  localparam int unsigned WBUF_DEPTH = 16;
  localparam int unsigned WBUF_RATIO = WBUF_OUT_W / WBUF_IN_W;
  localparam int unsigned WBUF_AW    = wbuf_clog2(WBUF_DEPTH);
  localparam int unsigned WBUF_RCW   = WBUF_AW + 1;

  localparam logic [WBUF_OUT_W-1:0] WBUF_ZERO_ROW = '0;

endpackage

// File: rtl/weight_buffer_pingpong_gen_if.sv
// AXI-Stream weight beat interface feeding the ping-pong weight buffer.
interface weight_buffer_pingpong_gen_if
  import wbuf_pkg::*;
#(
  parameter int unsigned IN_W = WBUF_IN_W
);
  logic [IN_W-1:0] tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/wbuf_gearbox.sv
// Packs IN_W-bit beats little-endian into OUT_W-bit rows.
// The row and commit strobe are combinational so a row commits on the same
// edge that accepts its final beat. A flush commits a partial row whose
// unfilled lanes are zero.
module wbuf_gearbox
  import wbuf_pkg::*;
#(
  parameter int unsigned IN_W  = WBUF_IN_W,
  parameter int unsigned OUT_W = WBUF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat_valid,
  input  logic [IN_W-1:0]  beat_data,
  input  logic             flush,
  input  logic             clear,
  output logic [OUT_W-1:0] row_c,
  output logic             commit_c
);

  localparam int unsigned RATIO = OUT_W / IN_W;
  localparam int unsigned CW    = (RATIO > 1) ? wbuf_clog2(RATIO) : 1;

  logic [OUT_W-1:0] row_q;
  logic [CW-1:0]    cnt_q;

  // Current row image with the incoming beat placed in its lane.
  always_comb begin
    row_c = row_q;
    row_c[int'(cnt_q) * IN_W +: IN_W] = beat_data;
    commit_c = beat_valid && ((cnt_q == CW'(RATIO - 1)) || flush);
  end

  // Lane accumulator; empties on commit so later partial rows pad with zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      row_q <= '0;
      cnt_q <= '0;
    end else if (beat_valid) begin
      if (commit_c) begin
        row_q <= '0;
        cnt_q <= '0;
      end else begin
        row_q <= row_c;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/weight_buffer_pingpong_gen.sv
// Ping-pong weight buffer: a gearbox fills the write bank from an AXI-Stream
// while the read bank streams one row per cycle into the systolic array.
// Optional feature macro: WBUF_TLAST_EN (tlast ends a tile early).
module weight_buffer_pingpong_gen
  import wbuf_pkg::*;
#(
  parameter  int unsigned IN_W  = WBUF_IN_W,
  parameter  int unsigned OUT_W = WBUF_OUT_W,
  parameter  int unsigned DEPTH = WBUF_DEPTH,
  localparam int unsigned AW    = wbuf_clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  weight_buffer_pingpong_gen_if.slave       s_axis,
  input  logic [AW:0]                       i_tile_rows,
  input  logic                              i_weight_load_en,
  input  logic                              i_bank_swap,
  output logic [OUT_W-1:0]                  o_weight_vec,
  output logic                              o_weight_valid,
  output logic                              o_wr_full,
  output logic                              o_rd_ready,
  output logic                              o_swap_err
);

  localparam int unsigned RCW = AW + 1;

  logic [OUT_W-1:0] mem [0:2*DEPTH-1];

  logic             bank_sel_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [RCW-1:0]   wr_rows_q;
  logic [RCW-1:0]   rd_rows_q;
  logic             tile_open_q;
  logic             wr_full_q;
  logic             tready_q;
  logic             rd_ready_q;
  logic             swap_err_q;
  logic             valid_q;
  logic [OUT_W-1:0] vec_q;

  logic             accept_c;
  logic             flush_c;
  logic [OUT_W-1:0] row_c;
  logic             commit_c;
  logic [RCW-1:0]   eff_rows_c;
  logic [RCW-1:0]   cur_rows_c;
  logic             tile_done_c;
  logic             swap_ok_c;
  logic             wr_full_d_c;
  logic             rd_hit_c;

`ifdef WBUF_TLAST_EN
  assign flush_c = accept_c & s_axis.tlast;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis.tlast;
  assign flush_c = 1'b0;
`endif

  wbuf_gearbox #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_gearbox (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_valid (accept_c),
    .beat_data  (s_axis.tdata),
    .flush      (flush_c),
    .clear      (swap_ok_c),
    .row_c      (row_c),
    .commit_c   (commit_c)
  );

  // Handshake, tile-length, swap-guard and read-hit decisions.
  always_comb begin
    accept_c    = s_axis.tvalid & tready_q;
    eff_rows_c  = ((i_tile_rows == '0) || (i_tile_rows > RCW'(DEPTH))) ? RCW'(DEPTH) : i_tile_rows;
    cur_rows_c  = tile_open_q ? wr_rows_q : eff_rows_c;
    tile_done_c = commit_c & ((RCW'(wr_ptr_q) == (cur_rows_c - RCW'(1))) | flush_c);
    swap_ok_c   = i_bank_swap & wr_full_q & ~i_weight_load_en;
    wr_full_d_c = swap_ok_c ? 1'b0 : (wr_full_q | tile_done_c);
    rd_hit_c    = i_weight_load_en & rd_ready_q & (RCW'(rd_ptr_q) < rd_rows_q);
  end

  // Write-side pointers, tile bookkeeping and bank swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_q  <= 1'b0;
      wr_ptr_q    <= '0;
      wr_rows_q   <= '0;
      rd_rows_q   <= '0;
      tile_open_q <= 1'b0;
      wr_full_q   <= 1'b0;
      tready_q    <= 1'b0;
      rd_ready_q  <= 1'b0;
      swap_err_q  <= 1'b0;
    end else begin
      wr_full_q <= wr_full_d_c;
      tready_q  <= ~wr_full_d_c;
      if (swap_ok_c) begin
        bank_sel_q  <= ~bank_sel_q;
        wr_ptr_q    <= '0;
        tile_open_q <= 1'b0;
        rd_rows_q   <= wr_rows_q;
        rd_ready_q  <= 1'b1;
      end else begin
        if (i_bank_swap) begin
          swap_err_q <= 1'b1;
        end
        if (accept_c && !tile_open_q) begin
          tile_open_q <= 1'b1;
          wr_rows_q   <= eff_rows_c;
        end
        if (commit_c) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (tile_done_c) begin
          wr_rows_q <= RCW'(wr_ptr_q) + RCW'(1);
        end
      end
    end
  end

  // Row storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (commit_c) begin
      mem[{bank_sel_q, wr_ptr_q}] <= row_c;
    end
  end

  // Read port: pointer restarts whenever load drops, row is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      vec_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (!i_weight_load_en) begin
        rd_ptr_q <= '0;
      end else if (rd_ptr_q != AW'(DEPTH - 1)) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      vec_q   <= rd_hit_c ? mem[{~bank_sel_q, rd_ptr_q}] : '0;
      valid_q <= rd_hit_c;
    end
  end

  assign s_axis.tready  = tready_q;
  assign o_weight_vec   = vec_q;
  assign o_weight_valid = valid_q;
  assign o_wr_full      = wr_full_q;
  assign o_rd_ready     = rd_ready_q;
  assign o_swap_err     = swap_err_q;

endmodule

// File: tb/tb_weight_buffer_pingpong_gen.sv
// Scoreboard bench for weight_buffer_pingpong_gen with a tile-level model.
module tb_weight_buffer_pingpong_gen;

  localparam int IN_W  = 64;
  localparam int OUT_W = 128;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RW    = AW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  weight_buffer_pingpong_gen_if #(.IN_W(IN_W)) s_if();

  logic [RW-1:0]    tile_rows;
  logic             load_en;
  logic             bank_swap;
  logic [OUT_W-1:0] wvec;
  logic             wvalid;
  logic             wr_full;
  logic             rd_ready;
  logic             swap_err;

  weight_buffer_pingpong_gen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis           (s_if),
    .i_tile_rows      (tile_rows),
    .i_weight_load_en (load_en),
    .i_bank_swap      (bank_swap),
    .o_weight_vec     (wvec),
    .o_weight_valid   (wvalid),
    .o_wr_full        (wr_full),
    .o_rd_ready       (rd_ready),
    .o_swap_err       (swap_err)
  );

  typedef struct {
    int               due;
    bit               v;
    logic [OUT_W-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Model: two banks of rows, the write bank index, and tile/flag state.
  logic [OUT_W-1:0] mbank [2][DEPTH];
  int               msel = 0;
  int               mwr_rows = 0;
  int               mrd_rows = 0;
  bit               mwr_full = 0;
  bit               mrd_ready = 0;
  bit               merr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle the registered read port either matches a due entry or is idle.
  always @(negedge clk) begin
    exp_t e;
    bit   hit;
    hit = 0;
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        hit = 1;
        checks++;
        if (wvalid !== e.v || wvec !== e.d) begin
          failures++;
          $display("FAIL read_row cyc=%0d actual valid=%0b vec=%0h required valid=%0b vec=%0h",
                   cyc, wvalid, wvec, e.v, e.d);
        end
      end
      if (!hit) begin
        checks++;
        if (wvalid !== 1'b0 || wvec !== '0) begin
          failures++;
          $display("FAIL idle_output cyc=%0d actual valid=%0b vec=%0h required valid=0 vec=0",
                   cyc, wvalid, wvec);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected read port value for the burst cycle that uses pointer index i.
  task automatic push_read(input int i);
    exp_t e;
    int   p;
    p = (i < DEPTH) ? i : DEPTH - 1;
    e.due = cyc + 1;
    e.v   = mrd_ready && (p < mrd_rows);
    e.d   = e.v ? mbank[1 - msel][p] : '0;
    exp_q.push_back(e);
  endtask

  task automatic drive_beat(input logic [IN_W-1:0] d, input bit last);
    int w;
    w = 0;
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    s_if.tlast  = last;
    while (s_if.tready !== 1'b1 && w < 64) begin
      step();
      w++;
    end
    if (w >= 64) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout actual tready=%0b required tready=1", s_if.tready);
    end else begin
      step();
    end
  endtask

  // Streams one tile; the model builds rows from beat pairs, padding a short last row.
  task automatic write_tile(input int rows_in, input int nbeats, input bit tl,
                            input bit rnd, input longint base);
    logic [IN_W-1:0] beats[$];
    logic [IN_W-1:0] d;
    logic [IN_W-1:0] hi;
    int              nrows;
    tile_rows = RW'(rows_in);
    for (int n = 0; n < nbeats; n++) begin
      if (n > 0) begin
        repeat ($urandom_range(0, 2)) begin
          s_if.tvalid = 1'b0;
          step();
        end
      end
      d = rnd ? {$urandom, $urandom} : IN_W'(base + longint'(n));
      beats.push_back(d);
      drive_beat(d, tl && (n == nbeats - 1));
      if (n == 0) tile_rows = RW'($urandom);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    nrows = (nbeats + 1) / 2;
    for (int r = 0; r < nrows; r++) begin
      hi = (2 * r + 1 < nbeats) ? beats[2 * r + 1] : '0;
      mbank[msel][r] = {hi, beats[2 * r]};
    end
    mwr_rows = nrows;
    mwr_full = 1;
    chk("wr_full_after_tile", wr_full, 1);
    chk("tready_low_when_full", s_if.tready, 0);
  endtask

  task automatic do_swap(input bit with_load);
    bit ok;
    ok = mwr_full && !with_load;
    bank_swap = 1'b1;
    load_en   = with_load;
    if (with_load) push_read(0);
    step();
    bank_swap = 1'b0;
    load_en   = 1'b0;
    if (ok) begin
      msel      = 1 - msel;
      mrd_rows  = mwr_rows;
      mrd_ready = 1;
      mwr_full  = 0;
    end else begin
      merr = 1;
    end
    chk("swap_err", swap_err, merr);
    chk("wr_full_after_swap", wr_full, mwr_full);
    chk("rd_ready_after_swap", rd_ready, mrd_ready);
    chk("tready_after_swap", s_if.tready, !mwr_full);
    if (with_load) step();
  endtask

  task automatic read_burst(input int n);
    for (int i = 0; i < n; i++) begin
      load_en = 1'b1;
      push_read(i);
      step();
    end
    load_en = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int eff;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    tile_rows   = '0;
    load_en     = 1'b0;
    bank_swap   = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_vec", wvec, 0);
    chk("rst_valid", wvalid, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_swap_err", swap_err, 0);
    chk("rst_tready", s_if.tready, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("tready_after_rst", s_if.tready, 1);

    // Full 12-row tile with data = beat index.
    write_tile(12, 24, 0, 0, 0);
    do_swap(0);
    read_burst(12);

    // Over-read past a 3-row tile, then re-read.
    write_tile(3, 6, 0, 1, 0);
    do_swap(0);
    read_burst(6);
    read_burst(6);

    // Swap guard: empty write bank, then load active; old tile stays readable.
    do_swap(0);
    write_tile(5, 10, 0, 1, 0);
    do_swap(1);
    read_burst(5);
    do_swap(0);
    chk("swap_err_sticky", swap_err, 1);
    read_burst(7);

    // Backpressure: beat 9 stalls until the swap frees the write bank.
    write_tile(4, 8, 0, 0, 1);
    s_if.tdata  = IN_W'(9);
    s_if.tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_tready_low", s_if.tready, 0);
      chk("bp_full_held", wr_full, 1);
    end
    do_swap(0);
    write_tile(4, 8, 0, 0, 9);
    read_burst(4);
    do_swap(0);
    read_burst(4);

    // Randomized tiles, row counts (including 0 and >DEPTH) and burst lengths.
    for (int it = 0; it < 8; it++) begin
      r   = $urandom_range(0, 20);
      eff = (r == 0 || r > DEPTH) ? DEPTH : r;
      write_tile(r, 2 * eff, 0, 1, 0);
      if ($urandom_range(0, 1) == 1) do_swap(1);
      do_swap(0);
      read_burst(eff + $urandom_range(0, 3));
      read_burst($urandom_range(1, eff));
    end

`ifdef WBUF_TLAST_EN
    // Early tlast on the fifth beat gives three rows, the last half-padded.
    write_tile(12, 5, 1, 0, 0);
    do_swap(0);
    read_burst(5);
`endif

    // Reset in the middle of a tile.
    tile_rows = RW'(12);
    for (int n = 0; n < 5; n++) drive_beat(IN_W'(100 + n), 1'b0);
    s_if.tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vec", wvec, 0);
    chk("mid_rst_valid", wvalid, 0);
    chk("mid_rst_wr_full", wr_full, 0);
    chk("mid_rst_rd_ready", rd_ready, 0);
    chk("mid_rst_swap_err", swap_err, 0);
    chk("mid_rst_tready", s_if.tready, 0);
    msel = 0;
    mwr_full = 0;
    mrd_ready = 0;
    mrd_rows = 0;
    merr = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("tready_after_mid_rst", s_if.tready, 1);
    read_burst(3);
    write_tile(12, 24, 0, 1, 0);
    do_swap(0);
    read_burst(12);

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
